guess_fifo: RTL and testbench

Parametrised receive-side guess buffer between the UART receiver and the game controller. It queues up to DEPTH received bytes instead of holding only the last one. Its optional ASCII filter accepts letters only and folds them to uppercase. It presents the head entry to the game logic through a valid/ready handshake, gated by the game-ready signal, and reports fill level, rejected bytes and overflow.

---
 rtl/guess_fifo.sv | 138 +++++++++++++
 tb/tb_guess_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/guess_fifo.sv
// Receive-side guess buffer: circular queue of UART bytes with an optional
// letters-only/uppercase filter, presented to the game through valid/ready.
module guess_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int FILTER_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          rx_byte,
    input  logic                       rx_ready,
    input  logic                       game_rdy,
    input  logic                       flush,
    input  logic                       guess_ready,
    output logic [DATA_W-1:0]          guess,
    output logic                       guess_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       rejected,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              rejected_q, rejected_d;

    logic              accepted_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              full_s;
    logic              empty_s;
    logic              valid_s;
    logic              push_s;
    logic              pop_s;

    // Letter filter: uppercase passes, lowercase folds down by 0x20, rest rejected.
    always_comb begin
        accepted_s = 1'b1;
        wr_data_s  = rx_byte;
        if (FILTER_EN != 0) begin
            if ((rx_byte >= DATA_W'(8'h41)) && (rx_byte <= DATA_W'(8'h5A))) begin
                accepted_s = 1'b1;
            end else if ((rx_byte >= DATA_W'(8'h61)) && (rx_byte <= DATA_W'(8'h7A))) begin
                wr_data_s = rx_byte - DATA_W'(8'h20);
            end else begin
                accepted_s = 1'b0;
            end
        end else begin
            accepted_s = 1'b1;
        end
    end

    // Status decodes and handshake qualifiers.
    always_comb begin
        full_s  = (count_q == CNT_W'(DEPTH));
        empty_s = (count_q == {CNT_W{1'b0}});
        valid_s = game_rdy & ~empty_s;
        pop_s   = valid_s & guess_ready & ~flush;
        push_s  = rx_ready & accepted_s & ~flush & (~full_s | pop_s);
    end

    // Next-state for pointers, count and status flags; flush overrides everything but rejected.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        rejected_d = rx_ready & ~accepted_s;
        if (flush) begin
            wr_ptr_d   = {PTR_W{1'b0}};
            rd_ptr_d   = {PTR_W{1'b0}};
            count_d    = {CNT_W{1'b0}};
            overflow_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                count_d = count_q;
            end
            if (rx_ready && accepted_s && full_s && !pop_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
            rejected_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rejected_q <= rejected_d;
        end
    end

    // Entry storage; contents are don't-care after reset, validity comes from count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data_s;
        end
    end

    assign guess       = valid_s ? mem_q[rd_ptr_q] : {DATA_W{1'b0}};
    assign guess_valid = valid_s;
    assign count       = count_q;
    assign empty       = empty_s;
    assign full        = full_s;
    assign rejected    = rejected_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_guess_fifo.sv
// Directed scoreboard bench for guess_fifo (DATA_W=8, DEPTH=4, FILTER_EN=1).
module tb_guess_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       game_rdy;
    logic       flush;
    logic       guess_ready;
    logic [7:0] guess;
    logic       guess_valid;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       rejected;
    logic       overflow;

    int         vectors;
    int         miscompares;
    logic [7:0] sb [$];
    logic [7:0] exp_b;

    guess_fifo #(.DATA_W(8), .DEPTH(4), .FILTER_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_byte    (rx_byte),
        .rx_ready   (rx_ready),
        .game_rdy   (game_rdy),
        .flush      (flush),
        .guess_ready(guess_ready),
        .guess      (guess),
        .guess_valid(guess_valid),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .rejected   (rejected),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one byte; acc/stored give the expected filter outcome.
    task automatic push(input logic [7:0] b, input logic acc, input logic [7:0] stored);
        rx_byte  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        if (acc && sb.size() < 4) sb.push_back(stored);
        chk("rejected", 32'(rejected), 32'(!acc));
    endtask

    // Pop the head and compare it against the scoreboard.
    task automatic pop(input string tag);
        chk({tag, "_valid"}, 32'(guess_valid), 32'd1);
        if (sb.size() > 0) exp_b = sb.pop_front();
        else exp_b = 8'h00;
        chk(tag, 32'(guess), 32'(exp_b));
        guess_ready = 1'b1;
        tick();
        guess_ready = 1'b0;
    endtask

    task automatic chk_count(input string tag);
        chk(tag, 32'(count), 32'(sb.size()));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        rx_byte     = 8'h00;
        rx_ready    = 1'b0;
        game_rdy    = 1'b1;
        flush       = 1'b0;
        guess_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Mid-run reset with rejected high and entries stored.
        push(8'h41, 1'b1, 8'h41);
        push(8'h31, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        sb.delete();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_valid", 32'(guess_valid), 32'd0);
        chk("rst_guess", 32'(guess), 32'd0);
        chk("rst_rejected", 32'(rejected), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Fill: first byte visible right after its push edge.
        push(8'h41, 1'b1, 8'h41);
        chk("lat_valid", 32'(guess_valid), 32'd1);
        chk("lat_guess", 32'(guess), 32'h41);
        push(8'h42, 1'b1, 8'h42);
        push(8'h43, 1'b1, 8'h43);
        chk("fill_count", 32'(count), 32'd3);
        chk("fill_head", 32'(guess), 32'h41);
        pop("fill_pop0");
        pop("fill_pop1");
        pop("fill_pop2");
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_guess", 32'(guess), 32'd0);

        // Filter: fold lowercase, reject digits.
        push(8'h61, 1'b1, 8'h41);
        push(8'h31, 1'b0, 8'h00);
        push(8'h5A, 1'b1, 8'h5A);
        chk("filt_count", 32'(count), 32'd2);
        pop("filt_pop0");
        pop("filt_pop1");

        // Overflow: five letters into four slots.
        push(8'h61, 1'b1, 8'h41);
        push(8'h42, 1'b1, 8'h42);
        push(8'h63, 1'b1, 8'h43);
        push(8'h44, 1'b1, 8'h44);
        chk("ovf_pre", 32'(overflow), 32'd0);
        push(8'h45, 1'b1, 8'h45);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) pop("ovf_pop");
        chk("ovf_empty", 32'(empty), 32'd1);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Full with simultaneous push and pop.
        push(8'h47, 1'b1, 8'h47);
        push(8'h48, 1'b1, 8'h48);
        push(8'h49, 1'b1, 8'h49);
        push(8'h4A, 1'b1, 8'h4A);
        chk("pp_head", 32'(guess), 32'h47);
        rx_byte     = 8'h6B;
        rx_ready    = 1'b1;
        guess_ready = 1'b1;
        tick();
        rx_ready    = 1'b0;
        guess_ready = 1'b0;
        void'(sb.pop_front());
        sb.push_back(8'h4B);
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) pop("pp_pop");

        // game_rdy gating.
        push(8'h4C, 1'b1, 8'h4C);
        push(8'h4D, 1'b1, 8'h4D);
        game_rdy    = 1'b0;
        guess_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("gate_guess", 32'(guess), 32'd0);
            chk("gate_valid", 32'(guess_valid), 32'd0);
            tick();
        end
        chk_count("gate_kept");
        push(8'h4E, 1'b1, 8'h4E);
        guess_ready = 1'b0;
        chk("gate_count", 32'(count), 32'd3);
        game_rdy = 1'b1;
        #1;
        chk("gate_head", 32'(guess), 32'h4C);
        for (int i = 0; i < 3; i++) pop("gate_pop");

        // Wrap-around: ten push/pop pairs.
        for (int i = 0; i < 10; i++) begin
            push(8'h50 + 8'(i), 1'b1, 8'h50 + 8'(i));
            pop("wrap_pop");
        end
        push(8'h71, 1'b1, 8'h51);
        chk_count("pre_flush_count");

        // Flush together with a valid byte.
        flush    = 1'b1;
        rx_byte  = 8'h5A;
        rx_ready = 1'b1;
        tick();
        flush    = 1'b0;
        rx_ready = 1'b0;
        sb.delete();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_ovf", 32'(overflow), 32'd0);
        chk("flush_valid", 32'(guess_valid), 32'd0);
        push(8'h52, 1'b1, 8'h52);
        chk_count("post_flush_count");
        pop("post_flush_pop");
        chk("final_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
